pong_ai_paddle_driver: RTL and testbench

Computer opponent for the Pong game: generates the up/down button commands that a paddle controller consumes in place of a human player. Watches the ball position in game units and the paddle's current Y, infers ball direction, waits a configurable reaction delay, then steers the paddle centre toward the ball. Sits between the ball controller and the right-hand paddle controller in the Pong top level.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_lfsr16.sv | 20 ++
 rtl/pong_ai_paddle_driver.sv | 130 +++++++++++++
 tb/tb_pong_ai_paddle_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong AI paddle driver: FSM states, default
// playfield dimensions and the LFSR constants used by the optional miss logic.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REACT,
        TRACK,
        CENTER
    } state_t;

    localparam int GAME_WIDTH    = 40;
    localparam int GAME_HEIGHT   = 30;
    localparam int PADDLE_HEIGHT = 6;
    localparam int PADDLE_X      = 39;
    localparam int REACT_DELAY   = 2500000;
    localparam int DEAD_BAND     = 1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/pong_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts left once per enabled clock; used as the
// random source for deliberate misses.
module pong_lfsr16
    import pong_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Enable,
    output logic [15:0] o_State
);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_State <= LFSR_SEED;
        end else if (i_Enable) begin
            o_State <= {o_State[14:0], lfsr_feedback(o_State)};
        end
    end

endmodule

// File: rtl/pong_ai_paddle_driver.sv
// Computer opponent that steers the right-hand paddle toward the ball after a
// reaction delay. Define PONG_AI_MISS_EN to enable occasional deliberate misses.
module pong_ai_paddle_driver
    import pong_pkg::*;
#(
    parameter int c_GAME_WIDTH    = GAME_WIDTH,
    parameter int c_GAME_HEIGHT   = GAME_HEIGHT,
    parameter int c_PADDLE_HEIGHT = PADDLE_HEIGHT,
    parameter int c_PADDLE_X      = PADDLE_X,
    parameter int c_REACT_DELAY   = REACT_DELAY,
    parameter int c_DEAD_BAND     = DEAD_BAND
) (
    input  logic                             i_Clk,
    input  logic                             i_Rst_L,
    input  logic                             i_Game_Active,
    input  logic [$clog2(c_GAME_WIDTH)-1:0]  i_Ball_X,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Ball_Y,
    input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Paddle_Y,
    output logic                             o_Paddle_Up,
    output logic                             o_Paddle_Dn,
    output logic                             o_Tracking
);

    localparam int c_X_W   = $clog2(c_GAME_WIDTH);
    localparam int c_Y_W   = $clog2(c_GAME_HEIGHT);
    localparam int c_A_W   = c_Y_W + 1;
    localparam int c_CNT_W = $clog2(c_REACT_DELAY + 1);

    localparam logic [c_X_W:0]   c_PX         = (c_X_W + 1)'(c_PADDLE_X);
    localparam logic [c_A_W-1:0] c_HALF       = c_A_W'(c_PADDLE_HEIGHT / 2);
    localparam logic [c_A_W-1:0] c_BAND       = c_A_W'(c_DEAD_BAND);
    localparam logic [c_A_W-1:0] c_HOME_TGT   = c_A_W'((c_GAME_HEIGHT - c_PADDLE_HEIGHT) / 2 + c_PADDLE_HEIGHT / 2);
    localparam logic [c_Y_W-1:0] c_WALL_Y     = c_Y_W'(c_GAME_HEIGHT - c_PADDLE_HEIGHT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_REACT_DELAY - 1);

    state_t              r_State, w_Next_State;
    logic [c_X_W-1:0]    r_Prev_X;
    logic                r_Approach;
    logic [c_CNT_W-1:0]  r_React_Cnt;
    logic [c_X_W:0]      w_New_Dist, w_Old_Dist;
    logic [c_A_W-1:0]    w_Centre, w_Target;
    logic                w_Want_Up, w_Want_Dn, w_Steer, w_Miss;

    assign w_New_Dist = ({1'b0, i_Ball_X} >= c_PX) ? {1'b0, i_Ball_X} - c_PX : c_PX - {1'b0, i_Ball_X};
    assign w_Old_Dist = ({1'b0, r_Prev_X} >= c_PX) ? {1'b0, r_Prev_X} - c_PX : c_PX - {1'b0, r_Prev_X};

    // Direction is only re-evaluated when the ball actually moves horizontally
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Prev_X   <= '0;
            r_Approach <= 1'b0;
        end else begin
            r_Prev_X <= i_Ball_X;
            if (i_Ball_X != r_Prev_X) begin
                r_Approach <= (w_New_Dist < w_Old_Dist);
            end
        end
    end

    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            IDLE:    w_Next_State = r_Approach ? REACT : CENTER;
            REACT:   if (!r_Approach) w_Next_State = CENTER;
                     else if (r_React_Cnt == c_CNT_LAST) w_Next_State = TRACK;
            TRACK:   if (!r_Approach) w_Next_State = CENTER;
            CENTER:  if (r_Approach) w_Next_State = REACT;
            default: w_Next_State = IDLE;
        endcase
        if (!i_Game_Active) begin
            w_Next_State = IDLE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= IDLE;
            r_React_Cnt <= '0;
        end else begin
            r_State     <= w_Next_State;
            r_React_Cnt <= (r_State == REACT && w_Next_State == REACT) ? r_React_Cnt + 1'b1 : '0;
        end
    end

`ifdef PONG_AI_MISS_EN
    logic [15:0] w_Lfsr;
    logic        r_Miss;

    pong_lfsr16 lfsr_inst (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (1'b1),
        .o_State  (w_Lfsr)
    );

    // The miss decision is latched once per approach and held until TRACK ends
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Miss <= 1'b0;
        end else if (r_State == REACT && w_Next_State == TRACK) begin
            r_Miss <= (w_Lfsr[2:0] == 3'd0);
        end else if (w_Next_State != TRACK) begin
            r_Miss <= 1'b0;
        end
    end

    assign w_Miss = r_Miss;
`else
    assign w_Miss = 1'b0;
`endif

    assign w_Centre  = {1'b0, i_Paddle_Y} + c_HALF;
    assign w_Target  = (r_State == TRACK) ? {1'b0, i_Ball_Y} : c_HOME_TGT;
    assign w_Want_Dn = (w_Centre + c_BAND < w_Target);
    assign w_Want_Up = (w_Centre > w_Target + c_BAND) && !w_Want_Dn;
    assign w_Steer   = i_Game_Active && (r_State == CENTER || (r_State == TRACK && !w_Miss));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Paddle_Up <= 1'b0;
            o_Paddle_Dn <= 1'b0;
            o_Tracking  <= 1'b0;
        end else begin
            o_Paddle_Up <= w_Steer && w_Want_Up && (i_Paddle_Y != '0);
            o_Paddle_Dn <= w_Steer && w_Want_Dn && (i_Paddle_Y != c_WALL_Y);
            o_Tracking  <= (w_Next_State == TRACK);
        end
    end

endmodule

// File: tb/tb_pong_ai_paddle_driver.sv
// Directed, table-driven bench for pong_ai_paddle_driver with a short
// reaction delay so the REACT window fits in a few cycles.
module tb_pong_ai_paddle_driver;

    typedef struct {
        logic       act;
        logic [5:0] x;
        logic [4:0] y;
        logic [4:0] p;
        logic       eu;
        logic       ed;
        logic       et;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       active;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic [4:0] paddle_y;
    logic       up, dn, trk;

    int total = 0;
    int bad   = 0;

    vec_t centerVecs[$];
    vec_t trackVecs[$];

    always #5 clk = ~clk;

    pong_ai_paddle_driver #(
        .c_REACT_DELAY (10)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Game_Active (active),
        .i_Ball_X      (ball_x),
        .i_Ball_Y      (ball_y),
        .i_Paddle_Y    (paddle_y),
        .o_Paddle_Up   (up),
        .o_Paddle_Dn   (dn),
        .o_Tracking    (trk)
    );

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic [5:0] x, input logic [4:0] y, input logic [4:0] p);
        active   = a;
        ball_x   = x;
        ball_y   = y;
        paddle_y = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("up_dn_exclusive", up & dn, 1'b0);
    endtask

    task automatic expect3(input string name, input logic eu, input logic ed, input logic et);
        checkOutput({name, ".up"}, up, eu);
        checkOutput({name, ".dn"}, dn, ed);
        checkOutput({name, ".trk"}, trk, et);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // CENTER target row is 15: Dn while centre < 14, Up while centre > 16
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd0,  1'b0, 1'b1, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd5,  1'b0, 1'b1, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd10, 1'b0, 1'b1, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd11, 1'b0, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd29, 5'd12, 1'b0, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd13, 1'b0, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd14, 1'b1, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd15, 1'b1, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd24, 1'b1, 1'b0, 1'b0});
        centerVecs.push_back('{1'b1, 6'd0, 5'd15, 5'd12, 1'b0, 1'b0, 1'b0});

        // TRACK target is the ball row; paddle centre is paddle_y + 3
        trackVecs.push_back('{1'b1, 6'd21, 5'd22, 5'd19, 1'b0, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd5,  5'd19, 1'b1, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd29, 5'd24, 1'b0, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd29, 5'd23, 1'b0, 1'b1, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd0,  5'd1,  1'b1, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd20, 5'd17, 1'b0, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd21, 5'd17, 1'b0, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd22, 5'd17, 1'b0, 1'b1, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd18, 5'd17, 1'b1, 1'b0, 1'b1});
        trackVecs.push_back('{1'b1, 6'd21, 5'd19, 5'd17, 1'b0, 1'b0, 1'b1});

        rst_n = 1'b0;
        applyStimulus(1'b1, 6'd0, 5'd15, 5'd0);
        repeat (3) tick();
        expect3("in_reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect3("first_edge_idle", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < centerVecs.size(); i++) begin
            applyStimulus(centerVecs[i].act, centerVecs[i].x, centerVecs[i].y, centerVecs[i].p);
            tick();
            expect3($sformatf("center%0d", i), centerVecs[i].eu, centerVecs[i].ed, centerVecs[i].et);
        end

        // Approach: direction registers on this edge, REACT starts on the next
        applyStimulus(1'b1, 6'd20, 5'd25, 5'd12);
        tick();
        expect3("approach_seen", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) ball_x = 6'd21;
            tick();
            expect3($sformatf("react%0d", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        expect3("track_entry", 1'b0, 1'b0, 1'b1);
        tick();
        expect3("track_first_cmd", 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < trackVecs.size(); i++) begin
            applyStimulus(trackVecs[i].act, trackVecs[i].x, trackVecs[i].y, trackVecs[i].p);
            tick();
            expect3($sformatf("track%0d", i), trackVecs[i].eu, trackVecs[i].ed, trackVecs[i].et);
        end

        applyStimulus(1'b1, 6'd21, 5'd25, 5'd12);
        tick();
        expect3("pre_drop", 1'b0, 1'b1, 1'b1);
        active = 1'b0;
        tick();
        expect3("drop", 1'b0, 1'b0, 1'b0);
        tick();
        expect3("drop_idle", 1'b0, 1'b0, 1'b0);

        // Re-activate while approaching, then turn away mid-REACT
        applyStimulus(1'b1, 6'd30, 5'd25, 5'd0);
        tick();
        expect3("reactivate", 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            expect3("react_again", 1'b0, 1'b0, 1'b0);
        end
        ball_x = 6'd29;
        tick();
        expect3("turn_away_seen", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) expect3("abort_edge", 1'b0, 1'b0, 1'b0);
            else        expect3($sformatf("abort_center%0d", i), 1'b0, 1'b1, 1'b0);
        end

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        expect3("async_reset", 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect3("post_reset_idle", 1'b0, 1'b0, 1'b0);
        tick();
        expect3("post_reset_center", 1'b0, 1'b1, 1'b0);
        tick();
        expect3("post_reset_react", 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
